// File: rtl/instr_fetch.sv
// instr_fetch: PC register, credit-limited in-order imem requests and a 2-entry decode FIFO.
// Redirects flush the FIFO and drop responses of in-flight wrong-path fetches.
module instr_fetch #(
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         pc_next,
    input  logic               is_jump,
    output logic [7:0]         pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [7:0]         imem_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [7:0]         if_pc,
    output logic [INSTR_W-1:0] if_instr
);
    logic [1:0]         outstanding, drop_cnt, fifo_count;
    logic [1:0]         qp, fp, out_next;
    logic               fire, take, pop;
    logic [7:0]         q_pc [2];
    logic [7:0]         f_pc [2];
    logic [INSTR_W-1:0] f_instr [2];

    assign if_valid  = fifo_count != 2'd0;
    assign imem_addr = pc;
    assign if_pc     = f_pc[0];
    assign if_instr  = f_instr[0];

    // live in-flight entries are outstanding minus those already marked for dropping
    always_comb begin
        imem_req_valid = !rst && !is_jump && ({1'b0, outstanding} + {1'b0, fifo_count} < 3'd2);
        fire = imem_req_valid & imem_req_ready;
        take = imem_rsp_valid && drop_cnt == 2'd0;
        pop = if_valid & if_ready;
        qp = outstanding - drop_cnt - {1'b0, take};
        fp = fifo_count - {1'b0, pop};
        out_next = outstanding + {1'b0, fire} - {1'b0, imem_rsp_valid};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= 8'h00;
            outstanding <= 2'd0;
            drop_cnt    <= 2'd0;
            fifo_count  <= 2'd0;
        end else begin
            pc          <= (fire || is_jump) ? pc_next : pc;
            outstanding <= out_next;
            drop_cnt    <= is_jump ? out_next : drop_cnt - {1'b0, imem_rsp_valid && drop_cnt != 2'd0};
            fifo_count  <= is_jump ? 2'd0 : fp + {1'b0, take};
        end
    end

    // shift-register queues: entry 0 is always the head
    always_ff @(posedge clk) begin
        q_pc[0]    <= (fire && qp == 2'd0) ? pc : (take ? q_pc[1] : q_pc[0]);
        q_pc[1]    <= (fire && qp == 2'd1) ? pc : q_pc[1];
        f_pc[0]    <= (take && fp == 2'd0) ? q_pc[0] : (pop ? f_pc[1] : f_pc[0]);
        f_instr[0] <= (take && fp == 2'd0) ? imem_rsp_data : (pop ? f_instr[1] : f_instr[0]);
        f_pc[1]    <= (take && fp == 2'd1) ? q_pc[0] : f_pc[1];
        f_instr[1] <= (take && fp == 2'd1) ? imem_rsp_data : f_instr[1];
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of instr_fetch against a bench memory and gen_next_pc model.
module tb_instr_fetch;
    logic        clk = 0;
    logic        rst = 1;
    logic [7:0]  pc_next, pc, imem_addr, if_pc, jump_addr = 8'h00;
    logic        is_jump = 0, imem_req_valid, imem_req_ready = 1;
    logic        imem_rsp_valid = 0, if_valid, if_ready = 1;
    logic [31:0] imem_rsp_data = 0, if_instr;

    typedef struct {logic [7:0] addr; int due;} mreq_t;
    mreq_t      mq[$];
    logic [7:0] reqs[$];
    logic [39:0] dlv[$];
    int tests = 0, fails = 0, cyc = 0, lat = 1;
    logic mem_ready = 1;

    always #5 clk = ~clk;
    assign pc_next = is_jump ? jump_addr : pc + 8'd4;

    instr_fetch #(.INSTR_W(32)) dut (
        .clk(clk), .rst(rst), .pc_next(pc_next), .is_jump(is_jump), .pc(pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr)
    );

    function automatic logic [31:0] mkdata(input logic [7:0] a);
        return {24'hC0FFEE, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock cycle: drive memory response, sample handshakes before the edge
    task automatic step();
        logic f, r, p, ok;
        imem_req_ready = mem_ready;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1;
            imem_rsp_data  = mkdata(mq[0].addr);
        end else begin
            imem_rsp_valid = 0;
            imem_rsp_data  = 0;
        end
        #1;
        f = imem_req_valid & imem_req_ready;
        r = imem_rsp_valid;
        p = if_valid & if_ready;
        if (r) void'(mq.pop_front());
        if (f) begin
            reqs.push_back(imem_addr);
            mq.push_back('{imem_addr, cyc + lat});
        end
        if (p) dlv.push_back({if_pc, if_instr});
        ok = dut.outstanding <= 2 && dut.fifo_count <= 2 && dut.drop_cnt <= dut.outstanding
             && ({1'b0, dut.outstanding} + {1'b0, dut.fifo_count}) <= 3'd2;
        chk("invariant", ok, 1);
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1;
        is_jump = 0;
        imem_rsp_valid = 0;
        @(negedge clk);
        @(negedge clk);
        mq.delete();
        reqs.delete();
        dlv.delete();
        cyc = 0;
        rst = 0;
    endtask

    task automatic clear_logs();
        reqs.delete();
        dlv.delete();
    endtask

    // requests and deliveries must form base, base+4, ... with matching data
    task automatic check_seq(input logic [7:0] base, input int min_n);
        logic [7:0] a;
        chk("req_count", reqs.size() >= min_n, 1);
        chk("dlv_count", dlv.size() >= min_n, 1);
        foreach (reqs[i]) begin
            a = base + 8'(4 * i);
            chk("req_addr", reqs[i], a);
        end
        foreach (dlv[i]) begin
            a = base + 8'(4 * i);
            chk("dlv_pc_instr", dlv[i], {a, mkdata(a)});
        end
    endtask

    initial begin
        // reset state
        @(negedge clk);
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_pc", pc, 8'h00);
        @(negedge clk);
        do_reset();
        #1;
        chk("first_req_valid", imem_req_valid, 1);
        chk("first_req_addr", imem_addr, 8'h00);
        @(negedge clk);
        mq.delete();
        // sequential fetch, 1-cycle memory
        do_reset();
        step();
        chk("if_valid_c1", if_valid, 0);
        step();
        chk("if_valid_c2", if_valid, 1);
        chk("if_pc_c2", if_pc, 8'h00);
        chk("if_instr_c2", if_instr, mkdata(8'h00));
        steps(12);
        check_seq(8'h00, 6);
        // backpressure
        do_reset();
        if_ready = 0;
        steps(6);
        chk("bp_req_count", reqs.size(), 2);
        chk("bp_if_valid", if_valid, 1);
        chk("bp_if_pc", if_pc, 8'h00);
        chk("bp_req_valid", imem_req_valid, 0);
        if_ready = 1;
        steps(10);
        check_seq(8'h00, 4);
        // async reset mid-stream with FIFO full
        do_reset();
        if_ready = 0;
        steps(6);
        chk("ar_full", if_valid, 1);
        chk("ar_pc_before", pc, 8'h08);
        #2 rst = 1;
        #1;
        chk("ar_if_valid", if_valid, 0);
        chk("ar_req_valid", imem_req_valid, 0);
        chk("ar_pc", pc, 8'h00);
        if_ready = 1;
        @(negedge clk);
        // jump flush with two requests outstanding, 3-cycle memory
        lat = 3;
        do_reset();
        steps(2);
        chk("jf_outstanding", reqs.size(), 2);
        is_jump = 1;
        jump_addr = 8'h40;
        step();
        is_jump = 0;
        chk("jf_if_valid", if_valid, 0);
        chk("jf_pc", pc, 8'h40);
        chk("jf_drop", dut.drop_cnt, 2);
        clear_logs();
        steps(14);
        check_seq(8'h40, 2);
        // jump coinciding with a response and a pop
        lat = 1;
        do_reset();
        steps(2);
        is_jump = 1;
        jump_addr = 8'h80;
        #1;
        chk("jc_pop", if_valid & imem_rsp_valid, 1);
        step();
        is_jump = 0;
        chk("jc_dlv_count", dlv.size(), 1);
        chk("jc_dlv0", dlv[0], {8'h00, mkdata(8'h00)});
        chk("jc_drop", dut.drop_cnt, 0);
        chk("jc_if_valid", if_valid, 0);
        chk("jc_pc", pc, 8'h80);
        clear_logs();
        steps(10);
        check_seq(8'h80, 4);
        // PC wrap
        do_reset();
        is_jump = 1;
        jump_addr = 8'hF8;
        step();
        is_jump = 0;
        clear_logs();
        steps(12);
        check_seq(8'hF8, 4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
